// File: rtl/uart_resp_tx_if.sv
// Response request channel between the command parser and the UART response transmitter.
// A request transfers when resp_valid && resp_ready are both high at a rising clock edge.
interface uart_resp_tx_if;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_code;
    logic [15:0] resp_value;

    modport master (
        output resp_valid,
        output resp_code,
        output resp_value,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_code,
        input  resp_value,
        output resp_ready
    );
endinterface

// File: rtl/uart_resp_tx.sv
// Formats an OK/ERR/VAL/BUSY response as an ASCII line and shifts it out 8N1, LSB first.
// uart_tx comes straight from a flop; each byte is looked up once, when it is loaded.
module uart_resp_tx #(
    parameter int CLKS_PER_BIT = 25,
    parameter int CNT_W        = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    uart_resp_tx_if.slave    resp,
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] CODE_OK   = 2'd0;
    localparam logic [1:0] CODE_ERR  = 2'd1;
    localparam logic [1:0] CODE_VAL  = 2'd2;
    localparam logic [1:0] CODE_BUSY = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       state_q,    state_d;
    logic [1:0]       code_q,     code_d;
    logic [15:0]      value_q,    value_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             tx_q,       tx_d;

    logic             bit_end;
    logic             last_byte;

    function automatic logic [7:0] hex_digit(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Index of the final byte (CR LF is always the last two).
    function automatic logic [2:0] last_idx(input logic [1:0] code);
        case (code)
            CODE_OK:   return 3'd3;
            CODE_ERR:  return 3'd4;
            CODE_VAL:  return 3'd7;
            default:   return 3'd5;
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [1:0] code,
                                          input logic [15:0] value,
                                          input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h0A;
        case (code)
            CODE_OK: begin
                case (idx)
                    3'd0:    b = 8'h4F;
                    3'd1:    b = 8'h4B;
                    3'd2:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
            CODE_ERR: begin
                case (idx)
                    3'd0:    b = 8'h45;
                    3'd1:    b = 8'h52;
                    3'd2:    b = 8'h52;
                    3'd3:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
            CODE_VAL: begin
                case (idx)
                    3'd0:    b = 8'h56;
                    3'd1:    b = 8'h3A;
                    3'd2:    b = hex_digit(value[15:12]);
                    3'd3:    b = hex_digit(value[11:8]);
                    3'd4:    b = hex_digit(value[7:4]);
                    3'd5:    b = hex_digit(value[3:0]);
                    3'd6:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
            default: begin
                case (idx)
                    3'd0:    b = 8'h42;
                    3'd1:    b = 8'h55;
                    3'd2:    b = 8'h53;
                    3'd3:    b = 8'h59;
                    3'd4:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
        endcase
        return b;
    endfunction

    assign bit_end   = (cnt_q == CNT_LAST);
    assign last_byte = (byte_idx_q == last_idx(code_q));

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        value_d    = value_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (resp.resp_valid) begin
                    state_d    = ST_START;
                    code_d     = resp.resp_code;
                    value_d    = resp.resp_value;
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd0;
                    cnt_d      = '0;
                    shift_d    = byte_at(resp.resp_code, resp.resp_value, 3'd0);
                    tx_d       = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // shift_q[1] becomes the new LSB on this edge
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (last_byte) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        state_d    = ST_START;
                        byte_idx_d = byte_idx_q + 1'b1;
                        shift_d    = byte_at(code_q, value_q, byte_idx_q + 1'b1);
                        tx_d       = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            code_q     <= 2'd0;
            value_q    <= 16'h0000;
            byte_idx_q <= 3'd0;
            bit_idx_q  <= 3'd0;
            cnt_q      <= '0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            value_q    <= value_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign resp.resp_ready = (state_q == ST_IDLE);
    assign uart_tx         = tx_q;
    assign tx_busy         = (state_q != ST_IDLE);
    assign tx_done         = (state_q == ST_STOP) && bit_end && last_byte;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_uart_resp_tx.sv
// Bench for uart_resp_tx: vector table of responses, a UART line monitor feeding a
// byte scoreboard, and hand-written back-to-back, input-stability and mid-frame reset cases.
module tb_uart_resp_tx;

    localparam int C = 25;

    typedef struct {
        logic [1:0]  code;
        logic [15:0] value;
        int          nbytes;
        logic [63:0] bytes;
    } vec_t;

    logic       sys_clk;
    logic       sys_rst;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_done;
    logic [1:0] state_dbg;

    uart_resp_tx_if resp_if ();

    uart_resp_tx #(.CLKS_PER_BIT(C), .CNT_W(5)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .resp      (resp_if.slave),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .state_dbg (state_dbg)
    );

    initial sys_clk = 1'b0;
    always #20 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int done_cnt = 0;
    always @(negedge sys_clk) if (tx_done === 1'b1) done_cnt = done_cnt + 1;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [63:0] bytes, input int n);
        logic [63:0] t;
        t = bytes;
        for (int i = 0; i < n; i++) exp_q.push_back(t[63-8*i -: 8]);
    endtask

    // UART line monitor: samples mid-bit; bytes interrupted by reset are discarded.
    initial begin : monitor
        logic [7:0] b;
        logic       start_v;
        logic       stop_v;
        bit         ab;
        forever begin
            @(negedge sys_clk);
            if (uart_tx === 1'b0 && sys_rst === 1'b0) begin
                ab = 0;
                for (int j = 0; j < C / 2; j++) begin
                    @(negedge sys_clk);
                    if (sys_rst) ab = 1;
                end
                start_v = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < C; j++) begin
                        @(negedge sys_clk);
                        if (sys_rst) ab = 1;
                    end
                    b[i] = uart_tx;
                end
                for (int j = 0; j < C; j++) begin
                    @(negedge sys_clk);
                    if (sys_rst) ab = 1;
                end
                stop_v = uart_tx;
                if (!ab) begin
                    check("rx_start_bit", start_v, 0);
                    check("rx_stop_bit", stop_v, 1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_unexpected_byte: got %02h expected none", b);
                    end else begin
                        check("rx_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic run_frame(input logic [1:0] code, input logic [15:0] value,
                             input int n, input bit disturb);
        int t0;
        int k;
        int viol;
        @(negedge sys_clk);
        check("ready_before_req", resp_if.resp_ready, 1);
        resp_if.resp_valid = 1'b1;
        resp_if.resp_code  = code;
        resp_if.resp_value = value;
        @(negedge sys_clk);
        resp_if.resp_valid = 1'b0;
        resp_if.resp_value = $urandom;
        check("start_after_accept", uart_tx, 0);
        check("busy_after_accept", tx_busy, 1);
        t0 = cyc;
        k = 0;
        viol = 0;
        while (tx_done !== 1'b1 && k < 20000) begin
            if (resp_if.resp_ready !== 1'b0 || tx_busy !== 1'b1) viol++;
            if (disturb && k == 500) begin
                resp_if.resp_valid = 1'b1;
                resp_if.resp_value = 16'($urandom);
                resp_if.resp_code  = 2'($urandom_range(0, 3));
            end
            if (disturb && k == 502) resp_if.resp_valid = 1'b0;
            @(negedge sys_clk);
            k++;
        end
        check("tx_done_seen", tx_done, 1);
        check("frame_cycles", cyc - t0 + 1, n * 10 * C);
        check("ready_low_in_frame", viol, 0);
        @(negedge sys_clk);
        check("idle_ready", resp_if.resp_ready, 1);
        check("idle_busy", tx_busy, 0);
        check("idle_tx", uart_tx, 1);
        check("done_one_cycle", tx_done, 0);
    endtask

    vec_t vecs[7];

    initial begin : stim
        int d0;
        int t1;
        int t2;
        int k;
        int lows;

        vecs[0] = '{2'd0, 16'h0000, 4, 64'h4F4B0D0A_00000000};
        vecs[1] = '{2'd2, 16'h2C1F, 8, 64'h563A3243_31460D0A};
        vecs[2] = '{2'd2, 16'hDE72, 8, 64'h563A4445_37320D0A};
        vecs[3] = '{2'd2, 16'h0000, 8, 64'h563A3030_30300D0A};
        vecs[4] = '{2'd2, 16'hFFFF, 8, 64'h563A4646_46460D0A};
        vecs[5] = '{2'd1, 16'h1234, 5, 64'h4552520D_0A000000};
        vecs[6] = '{2'd3, 16'hABCD, 6, 64'h42555359_0D0A0000};

        resp_if.resp_valid = 1'b0;
        resp_if.resp_code  = 2'd0;
        resp_if.resp_value = 16'h0000;

        // reset then idle
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_tx", uart_tx, 1);
        check("rst_ready", resp_if.resp_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        d0 = done_cnt;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("idle_no_done", done_cnt - d0, 0);
        check("idle_line_high", lows, 0);

        // vector table
        for (int v = 0; v < 7; v++) begin
            push_exp(vecs[v].bytes, vecs[v].nbytes);
            run_frame(vecs[v].code, vecs[v].value, vecs[v].nbytes, 1'b0);
            repeat (3) @(negedge sys_clk);
            check("queue_drained", exp_q.size(), 0);
        end

        // input stability: disturbance mid-frame must be ignored
        push_exp(64'h563A3132_33340D0A, 8);
        d0 = done_cnt;
        run_frame(2'd2, 16'h1234, 8, 1'b1);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_extra_frame", lows, 0);
        check("stab_done_count", done_cnt - d0, 1);
        check("stab_queue", exp_q.size(), 0);

        // back-to-back ERR then BUSY with resp_valid held high
        push_exp(64'h4552520D_0A000000, 5);
        push_exp(64'h42555359_0D0A0000, 6);
        d0 = done_cnt;
        @(negedge sys_clk);
        resp_if.resp_valid = 1'b1;
        resp_if.resp_code  = 2'd1;
        @(negedge sys_clk);
        resp_if.resp_code  = 2'd3;
        resp_if.resp_value = 16'h5A5A;
        k = 0;
        while (tx_done !== 1'b1 && k < 20000) begin
            @(negedge sys_clk);
            k++;
        end
        check("b2b_done1", tx_done, 1);
        t1 = cyc;
        @(negedge sys_clk);
        check("b2b_gap_tx", uart_tx, 1);
        check("b2b_gap_ready", resp_if.resp_ready, 1);
        k = 0;
        while (uart_tx !== 1'b0 && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        resp_if.resp_valid = 1'b0;
        t2 = cyc;
        check("b2b_gap_cycles", t2 - t1, 2);
        k = 0;
        while (tx_done !== 1'b1 && k < 20000) begin
            @(negedge sys_clk);
            k++;
        end
        check("b2b_frame2_cycles", cyc - t2 + 1, 6 * 10 * C);
        repeat (3) @(negedge sys_clk);
        check("b2b_done_pulses", done_cnt - d0, 2);
        check("b2b_queue", exp_q.size(), 0);

        // reset during data bit 3 of the second byte of a VAL frame
        push_exp(64'h56000000_00000000, 1);
        d0 = done_cnt;
        @(negedge sys_clk);
        resp_if.resp_valid = 1'b1;
        resp_if.resp_code  = 2'd2;
        resp_if.resp_value = 16'hA5C3;
        @(negedge sys_clk);
        resp_if.resp_valid = 1'b0;
        t1 = cyc;
        while (cyc < t1 + 14 * C + 5) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_tx", uart_tx, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_ready", resp_if.resp_ready, 1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 12 * C; i++) begin
            @(negedge sys_clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("midrst_line_high", lows, 0);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_queue", exp_q.size(), 0);
        push_exp(64'h4F4B0D0A_00000000, 4);
        run_frame(2'd0, 16'h0000, 4, 1'b0);
        repeat (20) @(negedge sys_clk);
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_resp_tx.md
Name: uart_resp_tx

Overview:
UART response transmitter for the TFT/SDRAM command path. It runs on the uart_tx side, opposite the command receiver that parses "TFT_x:..." lines on uart_rx. The command parser issues a response request, either a status or a 16-bit value. This block formats the request as an ASCII line and serialises it 8N1, LSB first, on uart_tx.

Parameters:
CLKS_PER_BIT, 25, sys_clk cycles per UART bit (25 MHz clock, 1 Mbaud); legal range >= 2.
CNT_W, 5, width of the bit-period counter; must satisfy 2^CNT_W >= CLKS_PER_BIT.

Ports:
sys_clk  input  1  system clock; all logic on the rising edge.
sys_rst  input  1  synchronous active-high reset.
resp_valid  input  1  response request.
resp_ready  output  1  block can accept a request; high only in IDLE.
resp_code  input  2  0=OK, 1=ERR, 2=VAL, 3=BUSY.
resp_value  input  16  payload, used only when resp_code=2.
uart_tx  output  1  serial line; idle high.
tx_busy  output  1  high from the accepting edge through the final stop bit.
tx_done  output  1  one-cycle pulse at the end of the final stop bit.

Behaviour:
- Reset (sys_rst=1 at a clock edge): uart_tx=1, resp_ready=1, tx_busy=0, tx_done=0. State goes to IDLE and all counters clear. Reset mid-frame aborts the frame; uart_tx is 1 on the next cycle.
- Handshake: a request is accepted when resp_valid && resp_ready at a clock edge. resp_code and resp_value are latched at that edge. Inputs are ignored while not in IDLE.
- Message byte sequences:
  - OK: 0x4F 0x4B 0x0D 0x0A (4 bytes).
  - ERR: 0x45 0x52 0x52 0x0D 0x0A (5 bytes).
  - VAL: 0x56 0x3A, then H3 H2 H1 H0, then 0x0D 0x0A (8 bytes).
  - BUSY: 0x42 0x55 0x53 0x59 0x0D 0x0A (6 bytes).
- Hex digits: Hn is nibble n of the latched value, most-significant nibble first. Values 0-9 map to 0x30+n; 10-15 map to 0x37+n (uppercase only).
- States: IDLE -> START -> DATA -> STOP.
  - IDLE -> START on handshake. START drives uart_tx=0 from the cycle after the accepting edge.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA holds each of the 8 bits for CLKS_PER_BIT cycles, LSB first, then goes to STOP.
  - STOP drives uart_tx=1 for CLKS_PER_BIT cycles.
  - At the end of STOP: if more bytes remain, go to START of the next byte with no extra idle gap. Otherwise go to IDLE.
- Byte index counts 0..len-1. Byte lookup is registered at byte load, so there are no combinational glitches on uart_tx; uart_tx is driven straight from a flop.
- Frame length is bytes × 10 × CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
- Timing of the frame end:
  - tx_done pulses in the last stop-bit cycle.
  - tx_busy falls with the transition to IDLE.
  - resp_ready is high on the following cycle.
  - A back-to-back request asserted on that cycle is accepted, so the minimum gap between frames is one idle cycle of uart_tx=1.
- Bit counter and byte index wrap only at their terminal counts. No other wrap-around is permitted.

Test Plan:
- Reset then idle: sys_rst high 3 cycles, release -> uart_tx=1, resp_ready=1, tx_busy=0, no tx_done for 100 cycles.
- OK: resp_code=0 -> bytes 0x4F,0x4B,0x0D,0x0A decoded by a bench UART monitor at 1000 ns/bit; tx_done exactly 1000 cycles after the first start-bit cycle; resp_ready low for the whole frame.
- VAL: resp_code=2, resp_value=0x2C1F -> "V:2C1F\r\n" = 0x56,0x3A,0x32,0x43,0x31,0x46,0x0D,0x0A in 2000 cycles. Repeat with value 0xDE72 -> digits 0x44,0x45,0x37,0x32. Check the 0x0000 and 0xFFFF digit boundaries.
- Input stability: change resp_value and pulse resp_valid mid-frame -> output is unchanged, the request is ignored, and no second frame is sent.
- Back-to-back: ERR followed by BUSY, with resp_valid held high -> 5-byte then 6-byte frame, separated by exactly one idle-high cycle; two tx_done pulses.
- Reset mid-frame: assert sys_rst during the data bit 3 of the second byte of a VAL frame -> uart_tx=1 the next cycle; no tx_done; after release, an OK request transmits correctly.
